shift_add_mult: RTL and testbench

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

---
 rtl/calc_pkg.sv | 13 +
 rtl/pp_and.sv | 13 +
 rtl/shift_add_mult.sv | 90 +++++++++
 tb/tb_shift_add_mult.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
// Holds the FSM state encoding and the default operand width.
package calc_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/pp_and.sv
// Partial-product gate: every bit of a vector ANDed with one select bit.
// Purely combinational.
module pp_and #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] vec,
    input  logic             sel,
    output logic [WIDTH-1:0] pp
);

    assign pp = vec & {WIDTH{sel}};

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier, signed or unsigned operands.
// Fixed latency: WIDTH RUN cycles plus one FIN cycle, then a done pulse.
module shift_add_mult
    import calc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t               state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic                 neg;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     pp;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   pp_ext;

    // -2^(WIDTH-1) negates to itself, which reads correctly as unsigned
    assign a_mag  = (sgn && a[WIDTH-1]) ? -a : a;
    assign b_mag  = (sgn && b[WIDTH-1]) ? -b : b;
    assign pp_ext = {{WIDTH{1'b0}}, pp} << cnt;
    assign busy   = (state == RUN) || (state == FIN);

    pp_and #(
        .WIDTH(WIDTH)
    ) u_pp (
        .vec(mcand),
        .sel(mplier[0]),
        .pp (pp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            neg     <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc + pp_ext;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    product <= neg ? -acc : acc;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed self-checking bench for shift_add_mult at WIDTH=4.
// Outputs are sampled on the falling clock edge.
module tb_shift_add_mult;

    logic       clk;
    logic       rst;
    logic       start;
    logic       sgn;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int checks = 0;
    int errors = 0;

    shift_add_mult #(
        .WIDTH(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sgn    (sgn),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .product(product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input logic s, input logic [3:0] x, input logic [3:0] y);
        @(negedge clk);
        sgn   = s;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcyc,
                             output bit ovl, output logic [7:0] p);
        lat  = 0;
        bcyc = 0;
        ovl  = 1'b0;
        p    = 'x;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            lat++;
            if (busy) bcyc++;
            if (busy && done) ovl = 1'b1;
            if (done) begin
                p = product;
                return;
            end
        end
        lat = -1;
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        sgn   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got %b want 0", done);
        end
        checks++;
        if (product !== 8'h00) begin
            errors++;
            $display("FAIL reset_product got %h want 00", product);
        end
    endtask

    task automatic test_unsigned;
        int lat, bc;
        bit ov;
        logic [7:0] p;
        issue(1'b0, 4'd13, 4'd11);
        wait_done(lat, bc, ov, p);
        checks++;
        if (p !== 8'h8F) begin
            errors++;
            $display("FAIL unsigned_13x11 got %h want 8f", p);
        end
        checks++;
        if (lat !== 6) begin
            errors++;
            $display("FAIL unsigned_latency got %0d want 6", lat);
        end
        checks++;
        if (bc !== 5) begin
            errors++;
            $display("FAIL unsigned_busy_cycles got %0d want 5", bc);
        end
        checks++;
        if (ov !== 1'b0) begin
            errors++;
            $display("FAIL unsigned_busy_done_overlap got %b want 0", ov);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_single_cycle got %b want 0", done);
        end
        checks++;
        if (product !== 8'h8F) begin
            errors++;
            $display("FAIL product_hold got %h want 8f", product);
        end
    endtask

    task automatic test_corners;
        logic [3:0] xa [3] = '{4'd0, 4'd15, 4'd1};
        logic [3:0] xb [3] = '{4'd0, 4'd15, 4'd15};
        logic [7:0] xp [3] = '{8'h00, 8'hE1, 8'h0F};
        int lat, bc;
        bit ov;
        logic [7:0] p;
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, xa[i], xb[i]);
            wait_done(lat, bc, ov, p);
            checks++;
            if (p !== xp[i]) begin
                errors++;
                $display("FAIL corner_%0d got %h want %h", i, p, xp[i]);
            end
            checks++;
            if (lat !== 6) begin
                errors++;
                $display("FAIL corner_%0d_latency got %0d want 6", i, lat);
            end
        end
    endtask

    task automatic test_signed;
        logic [3:0] xa [4] = '{4'hD, 4'h8, 4'h7, 4'h8};
        logic [3:0] xb [4] = '{4'h5, 4'h8, 4'hF, 4'h3};
        logic [7:0] xp [4] = '{8'hF1, 8'h40, 8'hF9, 8'hE8};
        int lat, bc;
        bit ov;
        logic [7:0] p;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, xa[i], xb[i]);
            wait_done(lat, bc, ov, p);
            checks++;
            if (p !== xp[i]) begin
                errors++;
                $display("FAIL signed_%0d got %h want %h", i, p, xp[i]);
            end
        end
        issue(1'b0, 4'h8, 4'h8);
        wait_done(lat, bc, ov, p);
        checks++;
        if (p !== 8'h40) begin
            errors++;
            $display("FAIL unsigned_8x8 got %h want 40", p);
        end
    endtask

    task automatic test_busy_start;
        int lat, bc, extra;
        bit ov;
        logic [7:0] p;
        issue(1'b0, 4'd5, 4'd6);
        @(negedge clk);
        a     = 4'd2;
        b     = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc, ov, p);
        checks++;
        if (p !== 8'h1E) begin
            errors++;
            $display("FAIL busy_start_product got %h want 1e", p);
        end
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL busy_start_extra_done got %0d want 0", extra);
        end
        checks++;
        if (product !== 8'h1E) begin
            errors++;
            $display("FAIL busy_start_hold got %h want 1e", product);
        end
    endtask

    task automatic test_reset_mid;
        int lat, bc, seen;
        bit ov;
        logic [7:0] p;
        issue(1'b0, 4'd5, 4'd5);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_flags got busy=%b done=%b want 0 0", busy, done);
        end
        checks++;
        if (product !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_product got %h want 00", product);
        end
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_mid_done got %0d want 0", seen);
        end
        issue(1'b0, 4'd3, 4'd3);
        wait_done(lat, bc, ov, p);
        checks++;
        if (p !== 8'h09) begin
            errors++;
            $display("FAIL rst_mid_after got %h want 09", p);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        bit ov;
        logic [7:0] p;
        @(negedge clk);
        sgn   = 1'b0;
        a     = 4'd2;
        b     = 4'd3;
        start = 1'b1;
        wait_done(lat, bc, ov, p);
        a = 4'd7;
        b = 4'd7;
        checks++;
        if (p !== 8'h06) begin
            errors++;
            $display("FAIL b2b_first got %h want 06", p);
        end
        checks++;
        if (ov !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first_overlap got %b want 0", ov);
        end
        wait_done(lat, bc, ov, p);
        start = 1'b0;
        checks++;
        if (p !== 8'h31) begin
            errors++;
            $display("FAIL b2b_second got %h want 31", p);
        end
        checks++;
        if (lat !== 6 || bc !== 5) begin
            errors++;
            $display("FAIL b2b_gap got lat=%0d busy=%0d want 6 5", lat, bc);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_quiet got busy=%b want 0", busy);
        end
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_corners;
        test_signed;
        test_busy_start;
        test_reset_mid;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
